// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: decodes the IR, sequences
// fetch/decode/execute/memory/writeback, and counts retired instructions.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE | check legality, latch branch target (old_pc + imm)
// MEMADR | compute load/store address rs1 + imm
// MEMRD  | load access at ALU-out address
// MEMWB  | rd <= memory data
// MEMWR  | store access at ALU-out address
// EXER   | register-register ALU op
// EXEI   | register-immediate ALU op
// ALUWB  | rd <= ALU-out register
// BRANCH | compare rs1/rs2, take branch on condition
// JAL    | PC <= target, compute link address
// TRAP   | illegal instruction or memory timeout; held until reset
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXER, S_EXEI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t          state, state_next;
  logic [WW-1:0]   wait_cnt;
  logic            req_state, timeout, legal;
  logic [3:0]      alu_f3;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Request is a function of state only, so the timeout path has no loop through mem_ready.
  assign req_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout   = (WAIT_LIMIT != 0) && req_state && !mem_ready &&
                     (wait_cnt == WW'(WAIT_LIMIT - 1));
  assign illegal   = (state == S_TRAP);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
      OP_R:   legal = (funct3 != 3'b011) &&
                      ((funct7 == 7'b0) || ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
      OP_I:   legal = (funct3 != 3'b011) &&
                      (((funct3 != 3'b001) && (funct3 != 3'b101)) || (funct7 == 7'b0));
      OP_B:   legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_f3 = ALU_ADD;
    case (funct3)
      3'b001: alu_f3 = 4'b0010;
      3'b010: alu_f3 = 4'b0011;
      3'b100: alu_f3 = 4'b0100;
      3'b101: alu_f3 = 4'b0101;
      3'b110: alu_f3 = 4'b0110;
      3'b111: alu_f3 = 4'b0111;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_STORE: imm_src = 3'b001;
      OP_B:     imm_src = 3'b010;
      OP_JAL:   imm_src = 3'b011;
      default:  imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (!legal) begin
          state_next = S_TRAP;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_R:    state_next = S_EXER;
            OP_I:    state_next = S_EXEI;
            OP_B:    state_next = S_BRANCH;
            OP_JAL:  state_next = S_JAL;
            default: state_next = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_next = S_MEMWB;
        else if (timeout) state_next = S_TRAP;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_next = S_FETCH;
        else if (timeout) state_next = S_TRAP;
      end
      S_EXER: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : alu_f3;
        state_next = S_ALUWB;
      end
      S_EXEI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_ctrl   = alu_f3;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = ALU_SUB;
        pc_write   = funct3[0] ? !zero : zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
    // Reset silences every strobe in the same cycle, not just from the next edge.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (req_state && !mem_ready) ? wait_cnt + WW'(1) : '0;
      if (state != S_FETCH && state_next == S_FETCH)
        instret <= instret + CNT_W'(1);
    end
  end

endmodule
